float_to_int: RTL and testbench

FLOAT_TO_INT -- requirements
Module: float_to_int

---
 rtl/float_to_int_if.sv | 31 +++
 rtl/float_to_int.sv | 150 +++++++++++++++
 tb/tb_float_to_int.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/float_to_int_if.sv
// Purpose: handshake bundle between a float producer, the float_to_int block and an int consumer.
// Latency: none, this only groups wires.
// Backpressure: stb/ack pairs on both sides; a transfer occurs on an edge where both are high.
interface float_to_int_if;
    logic [31:0] input_a;
    logic        input_a_stb;
    logic        input_a_ack;
    logic [31:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack;

    // Environment side: drives the operand and the result acknowledge.
    modport master (
        output input_a,
        output input_a_stb,
        output output_z_ack,
        input  input_a_ack,
        input  output_z,
        input  output_z_stb
    );

    // Converter side.
    modport slave (
        input  input_a,
        input  input_a_stb,
        input  output_z_ack,
        output input_a_ack,
        output output_z,
        output output_z_stb
    );
endinterface

// File: rtl/float_to_int.sv
// Purpose: IEEE-754 single to signed 32-bit integer, round toward zero, one operand at a time.
// Latency: 3 edges capture->output_z_stb for special cases, (36 - unbiased exponent) otherwise.
// Backpressure: output held stable while output_z_ack=0; no new operand is taken until the result is acknowledged.
// Option: FLOAT_TO_INT_SAT_EN makes infinities and too-large values saturate by sign instead of returning 0x80000000.
module float_to_int (
    input  logic         clk,
    input  logic         rst,
    float_to_int_if.slave bus
);

    typedef enum logic [2:0] {
        get_a,
        unpack,
        special_cases,
        convert,
        put_z
    } state_t;

    // Unbiased exponent codes: all-ones field and all-zeros field.
    localparam logic [9:0] E_INF  = 10'd128;
    localparam logic [9:0] E_ZERO = 10'h381;   // -127

    state_t      state, state_nxt;
    logic [31:0] a, a_nxt;
    logic [31:0] m, m_nxt;
    logic [9:0]  e, e_nxt;
    logic        s, s_nxt;
    logic [31:0] z, z_nxt;
    logic        ack_q, ack_nxt;
    logic        stb_q, stb_nxt;
    logic [31:0] out_q, out_nxt;
    logic [31:0] oor_val;

    assign bus.input_a_ack  = ack_q;
    assign bus.output_z_stb = stb_q;
    assign bus.output_z     = out_q;

    // Result for infinities and magnitudes of 2^31 or more.
    always_comb begin
`ifdef FLOAT_TO_INT_SAT_EN
        oor_val = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
        oor_val = 32'h8000_0000;
`endif
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= get_a;
            a     <= '0;
            m     <= '0;
            e     <= '0;
            s     <= 1'b0;
            z     <= '0;
            ack_q <= 1'b0;
            stb_q <= 1'b0;
            out_q <= '0;
        end else begin
            state <= state_nxt;
            a     <= a_nxt;
            m     <= m_nxt;
            e     <= e_nxt;
            s     <= s_nxt;
            z     <= z_nxt;
            ack_q <= ack_nxt;
            stb_q <= stb_nxt;
            out_q <= out_nxt;
        end
    end

    // Next-state and next-register values for the five-state sequencer.
    always_comb begin
        state_nxt = state;
        a_nxt     = a;
        m_nxt     = m;
        e_nxt     = e;
        s_nxt     = s;
        z_nxt     = z;
        ack_nxt   = ack_q;
        stb_nxt   = stb_q;
        out_nxt   = out_q;

        case (state)
            get_a: begin
                if (ack_q && bus.input_a_stb) begin
                    a_nxt     = bus.input_a;
                    ack_nxt   = 1'b0;
                    state_nxt = unpack;
                end else begin
                    ack_nxt = 1'b1;
                end
            end

            unpack: begin
                // Mantissa left-aligned with the hidden bit at [31].
                m_nxt     = {1'b1, a[22:0], 8'b0};
                e_nxt     = {2'b00, a[30:23]} - 10'd127;
                s_nxt     = a[31];
                state_nxt = special_cases;
            end

            special_cases: begin
                state_nxt = put_z;
                if (e == E_INF && a[22:0] != 23'd0) begin
                    z_nxt = 32'h8000_0000;
                end else if (e == E_INF) begin
                    z_nxt = oor_val;
                end else if (e == E_ZERO) begin
                    z_nxt = 32'h0;
                end else if (e[9]) begin
                    z_nxt = 32'h0;
                end else if (e > 10'd30) begin
                    z_nxt = oor_val;
                end else begin
                    state_nxt = convert;
                end
            end

            convert: begin
                // Shift one bit per cycle until the binary point sits below bit 0,
                // then spend one cycle registering the signed result before put_z.
                if (e == 10'd32) begin
                    state_nxt = put_z;
                end else if (e == 10'd31) begin
                    z_nxt = s ? (32'd0 - m) : m;
                    e_nxt = e + 10'd1;
                end else begin
                    m_nxt = m >> 1;
                    e_nxt = e + 10'd1;
                end
            end

            put_z: begin
                if (stb_q && bus.output_z_ack) begin
                    stb_nxt   = 1'b0;
                    state_nxt = get_a;
                end else begin
                    stb_nxt = 1'b1;
                    out_nxt = z;
                end
            end

            default: begin
                state_nxt = get_a;
            end
        endcase
    end

endmodule

// File: tb/tb_float_to_int.sv
// Purpose: directed self-checking bench for float_to_int.
// Latency: checks exact capture-to-valid edge counts.
// Backpressure: exercises held output_z_ack and continuous input_a_stb.
module tb_float_to_int;

    logic clk = 1'b0;
    logic rst;
    float_to_int_if bus();

    float_to_int dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

`ifdef FLOAT_TO_INT_SAT_EN
    localparam logic [31:0] OOR_POS = 32'h7FFF_FFFF;
`else
    localparam logic [31:0] OOR_POS = 32'h8000_0000;
`endif

    // Present one operand, wait for capture, count edges until output_z_stb, then let the ack complete.
    // Caller must be at posedge+1 with output_z_ack already high.
    task automatic run_op(input logic [31:0] op, output logic [31:0] res, output int lat, output bit ok);
        bit hs;
        ok  = 1'b0;
        res = '0;
        lat = 0;
        bus.input_a     = op;
        bus.input_a_stb = 1'b1;
        for (int i = 0; i < 100; i++) begin
            hs = bus.input_a_ack;
            @(posedge clk); #1;
            if (hs) begin
                ok = 1'b1;
                break;
            end
        end
        bus.input_a_stb = 1'b0;
        if (ok) begin
            ok = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(posedge clk); #1;
                lat++;
                if (bus.output_z_stb) begin
                    ok = 1'b1;
                    break;
                end
            end
            res = bus.output_z;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (bus.input_a_ack !== 1'b0) begin
            errors++; $display("FAIL reset_ack: got %b expected 0", bus.input_a_ack);
        end
        checks++;
        if (bus.output_z_stb !== 1'b0) begin
            errors++; $display("FAIL reset_stb: got %b expected 0", bus.output_z_stb);
        end
        checks++;
        if (bus.output_z !== 32'h0) begin
            errors++; $display("FAIL reset_z: got %h expected 00000000", bus.output_z);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.input_a_ack !== 1'b0) begin
            errors++; $display("FAIL reset_ack_held: got %b expected 0", bus.input_a_ack);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.input_a_ack !== 1'b1) begin
            errors++; $display("FAIL ack_after_release: got %b expected 1", bus.input_a_ack);
        end
    endtask

    task automatic test_convert();
        logic [31:0] ops  [7] = '{32'h3F80_0000, 32'hC020_0000, 32'h3F00_0000, 32'h0000_0001,
                                  32'h4EFF_FFFF, 32'h4E80_0000, 32'hBF80_0000};
        logic [31:0] exps [7] = '{32'h0000_0001, 32'hFFFF_FFFE, 32'h0000_0000, 32'h0000_0000,
                                  32'h7FFF_FF80, 32'h4000_0000, 32'hFFFF_FFFF};
        int          lats [7] = '{36, 35, 3, 3, 6, 6, 36};
        logic [31:0] res;
        int          lat;
        bit          ok;
        bus.output_z_ack = 1'b1;
        for (int k = 0; k < 7; k++) begin
            run_op(ops[k], res, lat, ok);
            checks++;
            if (!ok) begin
                errors++; $display("FAIL convert_timeout op=%h: no result, expected %h", ops[k], exps[k]);
            end else begin
                checks++;
                if (res !== exps[k]) begin
                    errors++; $display("FAIL convert_value op=%h: got %h expected %h", ops[k], res, exps[k]);
                end
                checks++;
                if (lat !== lats[k]) begin
                    errors++; $display("FAIL convert_latency op=%h: got %0d expected %0d", ops[k], lat, lats[k]);
                end
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] ops  [5] = '{32'h4F00_0000, 32'h7F80_0000, 32'hCF00_0000, 32'h7FC0_0000, 32'hFF80_0000};
        logic [31:0] exps [5] = '{OOR_POS, OOR_POS, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] res;
        int          lat;
        bit          ok;
        bus.output_z_ack = 1'b1;
        for (int k = 0; k < 5; k++) begin
            run_op(ops[k], res, lat, ok);
            checks++;
            if (!ok) begin
                errors++; $display("FAIL oor_timeout op=%h: no result, expected %h", ops[k], exps[k]);
            end else begin
                checks++;
                if (res !== exps[k]) begin
                    errors++; $display("FAIL oor_value op=%h: got %h expected %h", ops[k], res, exps[k]);
                end
                checks++;
                if (lat !== 3) begin
                    errors++; $display("FAIL oor_latency op=%h: got %0d expected 3", ops[k], lat);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit hs;
        bit got;
        got = 1'b0;
        bus.output_z_ack = 1'b0;
        bus.input_a      = 32'h4040_0000;
        bus.input_a_stb  = 1'b1;
        for (int i = 0; i < 100 && !got; i++) begin
            hs = bus.input_a_ack;
            @(posedge clk); #1;
            if (hs) got = 1'b1;
        end
        bus.input_a_stb = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge clk); #1;
            if (bus.output_z_stb) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++; $display("FAIL bp_timeout: output_z_stb got 0 expected 1");
        end else begin
            for (int c = 0; c < 20; c++) begin
                @(posedge clk); #1;
                checks++;
                if (bus.output_z_stb !== 1'b1 || bus.output_z !== 32'h3 || bus.input_a_ack !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_hold cycle %0d: got stb=%b z=%h a_ack=%b expected stb=1 z=00000003 a_ack=0",
                             c, bus.output_z_stb, bus.output_z, bus.input_a_ack);
                end
            end
            bus.output_z_ack = 1'b1;
            @(posedge clk); #1;
            bus.output_z_ack = 1'b0;
            checks++;
            if (bus.output_z_stb !== 1'b0 || bus.input_a_ack !== 1'b0) begin
                errors++; $display("FAIL bp_release: got stb=%b a_ack=%b expected stb=0 a_ack=0",
                                   bus.output_z_stb, bus.input_a_ack);
            end
            @(posedge clk); #1;
            checks++;
            if (bus.input_a_ack !== 1'b1) begin
                errors++; $display("FAIL bp_ack_return: got %b expected 1", bus.input_a_ack);
            end
        end
        bus.output_z_ack = 1'b1;
    endtask

    task automatic test_reset_mid();
        bit          hs;
        bit          got;
        bit          seen;
        logic [31:0] res;
        int          lat;
        bit          ok;
        got  = 1'b0;
        seen = 1'b0;
        bus.output_z_ack = 1'b1;
        bus.input_a      = 32'h3F80_0000;
        bus.input_a_stb  = 1'b1;
        for (int i = 0; i < 100 && !got; i++) begin
            hs = bus.input_a_ack;
            @(posedge clk); #1;
            if (hs) got = 1'b1;
        end
        bus.input_a_stb = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.input_a_ack !== 1'b0 || bus.output_z_stb !== 1'b0 || bus.output_z !== 32'h0) begin
            errors++; $display("FAIL mid_reset_async: got a_ack=%b stb=%b z=%h expected 0 0 00000000",
                               bus.input_a_ack, bus.output_z_stb, bus.output_z);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        for (int c = 0; c < 45; c++) begin
            @(posedge clk); #1;
            if (bus.output_z_stb) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL mid_reset_no_output: got output_z_stb=1 expected 0");
        end
        run_op(32'h4040_0000, res, lat, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL post_reset_timeout: no result, expected 00000003");
        end else begin
            checks++;
            if (res !== 32'h3) begin
                errors++; $display("FAIL post_reset_value: got %h expected 00000003", res);
            end
            checks++;
            if (lat !== 35) begin
                errors++; $display("FAIL post_reset_latency: got %0d expected 35", lat);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ops  [5] = '{32'h4040_0000, 32'hC020_0000, 32'h3F80_0000, 32'h4120_0000, 32'h0000_0000};
        logic [31:0] exps [5] = '{32'h0000_0003, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_000A, 32'h0000_0000};
        logic [31:0] results[$];
        bit          tmo;
        tmo = 1'b0;
        bus.output_z_ack = 1'b1;
        fork
            begin
                for (int k = 0; k < 5; k++) begin
                    bit hs;
                    bit got;
                    got = 1'b0;
                    bus.input_a     = ops[k];
                    bus.input_a_stb = 1'b1;
                    for (int i = 0; i < 100 && !got; i++) begin
                        hs = bus.input_a_ack;
                        @(posedge clk); #1;
                        if (hs) got = 1'b1;
                    end
                    if (!got) tmo = 1'b1;
                end
                bus.input_a_stb = 1'b0;
            end
            begin
                for (int c = 0; c < 300; c++) begin
                    @(posedge clk); #1;
                    if (bus.output_z_stb) results.push_back(bus.output_z);
                end
            end
        join
        checks++;
        if (tmo) begin
            errors++; $display("FAIL b2b_capture_timeout: got timeout expected all captured");
        end
        checks++;
        if (results.size() !== 5) begin
            errors++; $display("FAIL b2b_count: got %0d results expected 5", results.size());
        end
        for (int k = 0; k < 5; k++) begin
            if (k < results.size()) begin
                checks++;
                if (results[k] !== exps[k]) begin
                    errors++; $display("FAIL b2b_value[%0d]: got %h expected %h", k, results[k], exps[k]);
                end
            end
        end
    endtask

    initial begin
        rst              = 1'b0;
        bus.input_a      = '0;
        bus.input_a_stb  = 1'b0;
        bus.output_z_ack = 1'b0;
        test_reset();
        test_convert();
        test_out_of_range();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
